// File: rtl/cycle_det_pkg.sv
// Shared constants and helpers for the periodic-pattern detector.
// Imported by cycle_hist and cycle_det.
package cycle_det_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_LAG   = 8;
    localparam int DEF_CNT_W     = 8;
    localparam int DEF_FILL_GATE = 1;

    // Width needed to encode lag values 0..max_lag (0 is kept so it can be flagged illegal).
    function automatic int lag_w(input int max_lag);
        return $clog2(max_lag + 1);
    endfunction

    // Increment that holds at 2^w-1; callers cast the result back to w bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] mx;
        mx = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= mx) ? mx : v + 32'd1;
    endfunction

endpackage

// File: rtl/cycle_hist.sv
// Valid-gated sample history: hist[k] is the k-th most recent valid sample.
// Also tracks how many samples have arrived and returns the hist[lag] tap.
module cycle_hist
    import cycle_det_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_LAG = DEF_MAX_LAG,
    parameter int LAG_W   = lag_w(DEF_MAX_LAG)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] din,
    input  logic [LAG_W-1:0] lag,
    output logic [WIDTH-1:0] hist_tap,
    output logic [LAG_W-1:0] fill_cnt,
    output logic             hist_full
);

    logic [WIDTH-1:0] hist_q [1:MAX_LAG];
    logic [LAG_W-1:0] fill_cnt_q;
    logic [LAG_W-1:0] fill_cnt_d;
    logic             hist_full_q;

    always_comb begin
        fill_cnt_d = fill_cnt_q;
        if (in_valid && (fill_cnt_q != LAG_W'(MAX_LAG))) begin
            fill_cnt_d = fill_cnt_q + LAG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            for (int k = 1; k <= MAX_LAG; k++) begin
                hist_q[k] <= '0;
            end
            fill_cnt_q  <= '0;
            hist_full_q <= 1'b0;
        end else begin
            if (in_valid) begin
                hist_q[1] <= din;
                for (int k = 2; k <= MAX_LAG; k++) begin
                    hist_q[k] <= hist_q[k-1];
                end
            end
            fill_cnt_q  <= fill_cnt_d;
            hist_full_q <= (fill_cnt_d == LAG_W'(MAX_LAG));
        end
    end

    // Out-of-range lag returns zero; the compare is masked by lag_ok anyway.
    always_comb begin
        hist_tap = '0;
        for (int k = 1; k <= MAX_LAG; k++) begin
            if (lag == LAG_W'(k)) begin
                hist_tap = hist_q[k];
            end
        end
    end

    assign fill_cnt  = fill_cnt_q;
    assign hist_full = hist_full_q;

endmodule

// File: rtl/cycle_det.sv
// Periodic-pattern detector: compares each valid sample with the one `lag` samples back,
// and reports a match pulse, a saturating run length and a threshold lock.
module cycle_det
    import cycle_det_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_LAG   = DEF_MAX_LAG,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int FILL_GATE = DEF_FILL_GATE,
    localparam int LAG_W    = lag_w(MAX_LAG)
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] din,
    input  logic [LAG_W-1:0] lag,
    input  logic [CNT_W-1:0] thresh,
    output logic             match,
    output logic [CNT_W-1:0] run_len,
    output logic             locked,
    output logic             hist_full,
    output logic             lag_err
);

    // in_valid has no back-pressure: every cycle with in_valid=1 delivers one sample
    // that is consumed on that clock edge; din is ignored when in_valid=0.

    logic [WIDTH-1:0] hist_tap;
    logic [LAG_W-1:0] fill_cnt;
    logic             lag_ok;
    logic             avail;
    logic             cmp;
    logic [CNT_W-1:0] run_len_inc;
    logic [CNT_W-1:0] run_len_d;
    logic [CNT_W-1:0] run_len_q;
    logic             locked_d;
    logic             locked_q;
    logic             match_q;
    logic             lag_err_q;
    logic [LAG_W-1:0] lag_q;

    cycle_hist #(
        .WIDTH   (WIDTH),
        .MAX_LAG (MAX_LAG),
        .LAG_W   (LAG_W)
    ) u_hist (
        .clk       (clk),
        .n_reset   (n_reset),
        .in_valid  (in_valid),
        .din       (din),
        .lag       (lag),
        .hist_tap  (hist_tap),
        .fill_cnt  (fill_cnt),
        .hist_full (hist_full)
    );

    always_comb begin
        lag_ok      = (lag != '0) && (lag <= LAG_W'(MAX_LAG));
        avail       = (FILL_GATE == 0) || (fill_cnt >= lag);
        cmp         = in_valid && lag_ok && avail && (din == hist_tap);
        run_len_inc = CNT_W'(sat_inc(32'(run_len_q), CNT_W));
        run_len_d   = run_len_q;
        // A lag change restarts the run even on idle cycles.
        if (lag != lag_q) begin
            run_len_d = cmp ? CNT_W'(1) : '0;
        end else if (in_valid) begin
            run_len_d = cmp ? run_len_inc : '0;
        end
        locked_d = (thresh != '0) && (run_len_d >= thresh);
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            match_q   <= 1'b0;
            run_len_q <= '0;
            locked_q  <= 1'b0;
            lag_err_q <= 1'b0;
            lag_q     <= '0;
        end else begin
            match_q   <= cmp;
            run_len_q <= run_len_d;
            locked_q  <= locked_d;
            lag_err_q <= !lag_ok;
            lag_q     <= lag;
        end
    end

    assign match   = match_q;
    assign run_len = run_len_q;
    assign locked  = locked_q;
    assign lag_err = lag_err_q;

endmodule

// File: tb/tb_cycle_det.sv
// Self-checking bench for cycle_det: three instances (default, FILL_GATE=0, CNT_W=4)
// share stimulus; a per-cycle reference model feeds a scoreboard, tasks add targeted checks.
module tb_cycle_det;

    localparam logic [7:0] A = 8'h5A;
    localparam logic [7:0] B = 8'hC3;
    localparam logic [7:0] C = 8'h11;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       in_valid;
    logic [7:0] din;
    logic [3:0] lag;
    logic [7:0] thresh;

    logic       m_match, m_locked, m_full, m_err;
    logic [7:0] m_run;
    logic       l_match, l_locked, l_full, l_err;
    logic [7:0] l_run;
    logic       c_match, c_locked, c_full, c_err;
    logic [3:0] c_run;

    int checks = 0;
    int errors = 0;

    logic [35:0] exp_q[$];

    // reference model state, one slot per instance: 0 default, 1 legacy, 2 CNT_W=4
    logic [7:0] md_hist [3][9];
    int         md_fill [3];
    logic [3:0] md_lagq [3];
    int         md_run  [3];

    always #5 clk = ~clk;

    cycle_det dut (
        .clk(clk), .n_reset(n_reset), .in_valid(in_valid), .din(din), .lag(lag),
        .thresh(thresh), .match(m_match), .run_len(m_run), .locked(m_locked),
        .hist_full(m_full), .lag_err(m_err)
    );

    cycle_det #(.FILL_GATE(0)) dut_leg (
        .clk(clk), .n_reset(n_reset), .in_valid(in_valid), .din(din), .lag(lag),
        .thresh(thresh), .match(l_match), .run_len(l_run), .locked(l_locked),
        .hist_full(l_full), .lag_err(l_err)
    );

    cycle_det #(.CNT_W(4)) dut_c4 (
        .clk(clk), .n_reset(n_reset), .in_valid(in_valid), .din(din), .lag(lag),
        .thresh(thresh[3:0]), .match(c_match), .run_len(c_run), .locked(c_locked),
        .hist_full(c_full), .lag_err(c_err)
    );

    // Computes the expected post-edge outputs of all three instances for the current inputs.
    task automatic model_push();
        logic [35:0] e;
        logic [11:0] o;
        logic        lag_ok, avail, cmp, lk, fg;
        int          cmax, th, li, rn;
        e = '0;
        for (int i = 0; i < 3; i++) begin
            fg   = (i != 1);
            cmax = (i == 2) ? 15 : 255;
            th   = (i == 2) ? int'(thresh[3:0]) : int'(thresh);
            if (!n_reset) begin
                for (int k = 0; k < 9; k++) md_hist[i][k] = 8'h00;
                md_fill[i] = 0;
                md_lagq[i] = 4'd0;
                md_run[i]  = 0;
                o = '0;
            end else begin
                lag_ok = (lag >= 4'd1) && (lag <= 4'd8);
                li     = lag_ok ? int'(lag) : 1;
                avail  = !fg || (md_fill[i] >= int'(lag));
                cmp    = in_valid && lag_ok && avail && (din == md_hist[i][li]);
                if (lag != md_lagq[i]) rn = cmp ? 1 : 0;
                else if (in_valid) rn = cmp ? ((md_run[i] >= cmax) ? cmax : md_run[i] + 1) : 0;
                else rn = md_run[i];
                lk = (th != 0) && (rn >= th);
                if (in_valid) begin
                    for (int k = 8; k >= 2; k--) md_hist[i][k] = md_hist[i][k-1];
                    md_hist[i][1] = din;
                    if (md_fill[i] < 8) md_fill[i]++;
                end
                md_run[i]  = rn;
                md_lagq[i] = lag;
                o = {cmp, 8'(rn), lk, (md_fill[i] == 8), !lag_ok};
            end
            e[i*12 +: 12] = o;
        end
        exp_q.push_back(e);
    endtask

    // Scoreboard: outputs settle after the posedge, compared on the following negedge.
    always @(negedge clk) begin
        logic [35:0] e;
        logic [11:0] obs [3];
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            obs[0] = {m_match, m_run, m_locked, m_full, m_err};
            obs[1] = {l_match, l_run, l_locked, l_full, l_err};
            obs[2] = {c_match, 4'h0, c_run, c_locked, c_full, c_err};
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== e[i*12 +: 12]) begin
                    errors++;
                    $display("FAIL scoreboard inst%0d t=%0t got %h expected %h", i, $time, obs[i], e[i*12 +: 12]);
                end
            end
        end
    end

    task automatic step(input logic v, input logic [7:0] d);
        in_valid = v;
        din      = d;
        model_push();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        n_reset = 1'b1;
    endtask

    task automatic test_reset();
        lag = 4'd2;
        thresh = 8'd3;
        n_reset = 1'b0;
        step(1'b1, 8'h77);
        step(1'b1, 8'h77);
        checks++;
        if ({m_match, m_run, m_locked, m_full, m_err} !== 12'h000) begin
            errors++;
            $display("FAIL reset_state got %h expected 000", {m_match, m_run, m_locked, m_full, m_err});
        end
        n_reset = 1'b1;
        step(1'b1, 8'h77);
        checks++;
        if (m_match !== 1'b0) begin
            errors++;
            $display("FAIL reset_drops_sample match got %b expected 0", m_match);
        end
    endtask

    task automatic test_basic();
        logic [7:0] seq [8] = '{A, B, A, B, A, B, A, B};
        logic       em  [6] = '{0, 0, 1, 1, 1, 1};
        int         er  [6] = '{0, 0, 1, 2, 3, 4};
        logic       el  [6] = '{0, 0, 0, 0, 1, 1};
        do_reset();
        lag = 4'd2;
        thresh = 8'd3;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, seq[i]);
            if (i < 6) begin
                checks++;
                if (m_match !== em[i] || m_run !== 8'(er[i]) || m_locked !== el[i] || m_full !== 1'b0) begin
                    errors++;
                    $display("FAIL basic[%0d] got m=%b r=%0d l=%b f=%b expected m=%b r=%0d l=%b f=0",
                             i, m_match, m_run, m_locked, m_full, em[i], er[i], el[i]);
                end
            end
        end
        checks++;
        if (m_full !== 1'b1) begin
            errors++;
            $display("FAIL hist_full_after_8 got %b expected 1", m_full);
        end
    endtask

    task automatic test_idle();
        logic [7:0] seq [6] = '{A, B, A, B, A, B};
        logic       em  [6] = '{0, 0, 1, 1, 1, 1};
        int         er  [6] = '{0, 0, 1, 2, 3, 4};
        do_reset();
        lag = 4'd2;
        thresh = 8'd3;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, seq[i]);
            checks++;
            if (m_match !== em[i] || m_run !== 8'(er[i])) begin
                errors++;
                $display("FAIL idle_valid[%0d] got m=%b r=%0d expected m=%b r=%0d", i, m_match, m_run, em[i], er[i]);
            end
            step(1'b0, 8'(i * 37));
            checks++;
            if (m_match !== 1'b0 || m_run !== 8'(er[i])) begin
                errors++;
                $display("FAIL idle_gap[%0d] got m=%b r=%0d expected m=0 r=%0d", i, m_match, m_run, er[i]);
            end
        end
    endtask

    task automatic test_lag_change();
        logic [7:0] seq [3] = '{A, B, C};
        logic       el  [3] = '{0, 0, 1};
        lag = 4'd3;
        step(1'b1, C);
        checks++;
        if (m_run !== 8'd0 || m_locked !== 1'b0) begin
            errors++;
            $display("FAIL lag_switch got r=%0d l=%b expected r=0 l=0", m_run, m_locked);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, seq[i]);
            checks++;
            if (m_match !== 1'b1 || m_run !== 8'(i + 1) || m_locked !== el[i]) begin
                errors++;
                $display("FAIL relock[%0d] got m=%b r=%0d l=%b expected m=1 r=%0d l=%b",
                         i, m_match, m_run, m_locked, i + 1, el[i]);
            end
        end
    endtask

    task automatic test_lag_err();
        lag = 4'd0;
        step(1'b1, A);
        checks++;
        if (m_err !== 1'b1 || m_match !== 1'b0 || m_run !== 8'd0 || m_locked !== 1'b0) begin
            errors++;
            $display("FAIL lag0 got e=%b m=%b r=%0d l=%b expected e=1 m=0 r=0 l=0", m_err, m_match, m_run, m_locked);
        end
        lag = 4'd9;
        step(1'b0, B);
        checks++;
        if (m_err !== 1'b1 || m_match !== 1'b0) begin
            errors++;
            $display("FAIL lag9_idle got e=%b m=%b expected e=1 m=0", m_err, m_match);
        end
        step(1'b1, B);
        checks++;
        if (m_err !== 1'b1 || m_run !== 8'd0 || m_match !== 1'b0) begin
            errors++;
            $display("FAIL lag9_valid got e=%b r=%0d m=%b expected e=1 r=0 m=0", m_err, m_run, m_match);
        end
        lag = 4'd2;
        step(1'b0, 8'h00);
        checks++;
        if (m_err !== 1'b0) begin
            errors++;
            $display("FAIL lag_restore got e=%b expected 0", m_err);
        end
    endtask

    task automatic test_fill_gate();
        logic em [3] = '{0, 0, 1};
        do_reset();
        lag = 4'd2;
        thresh = 8'd3;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h00);
            checks++;
            if (l_match !== 1'b1 || m_match !== em[i]) begin
                errors++;
                $display("FAIL fill_gate[%0d] got legacy=%b gated=%b expected legacy=1 gated=%b",
                         i, l_match, m_match, em[i]);
            end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        lag = 4'd1;
        thresh = 8'd5;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'h3C);
            checks++;
            if (c_run !== 4'((i > 15) ? 15 : i) || m_run !== 8'(i)) begin
                errors++;
                $display("FAIL saturate[%0d] got c4=%0d def=%0d expected c4=%0d def=%0d",
                         i, c_run, m_run, (i > 15) ? 15 : i, i);
            end
        end
        n_reset = 1'b0;
        step(1'b1, 8'h3C);
        checks++;
        if ({m_match, m_run, m_locked, m_full, m_err} !== 12'h000 ||
            {c_match, c_run, c_locked, c_full, c_err} !== 8'h00) begin
            errors++;
            $display("FAIL midrun_reset got def=%h c4=%h expected 0",
                     {m_match, m_run, m_locked, m_full, m_err}, {c_match, c_run, c_locked, c_full, c_err});
        end
        n_reset = 1'b1;
        step(1'b1, 8'h3C);
        checks++;
        if (m_match !== 1'b0 || c_match !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_first got def=%b c4=%b expected 0", m_match, c_match);
        end
    endtask

    task automatic test_random();
        lag = 4'd4;
        thresh = 8'd2;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) lag = 4'($urandom_range(0, 9));
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        n_reset  = 1'b0;
        in_valid = 1'b0;
        din      = 8'h00;
        lag      = 4'd2;
        thresh   = 8'd3;
        test_reset();
        test_basic();
        test_idle();
        test_lag_change();
        test_lag_err();
        test_fill_gate();
        test_saturate();
        test_random();
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cycle_det.md
Name: cycle_det

Overview:
- Parametrised periodic-pattern detector.
- Compares each valid input sample against the sample received `lag` valid samples earlier. Produces a per-sample match pulse, a saturating run-length of consecutive matches, and a `locked` flag once the run reaches a programmable threshold.
- Sits on sampled data buses (switch/keypad/sequence streams) downstream of the input synchroniser. Generalises the fixed 2-deep period checker to runtime lag, arbitrary width and valid-gated sampling.

Parameters:
- WIDTH, 8, sample width in bits.
- MAX_LAG, 8, deepest supported lag (history depth), >= 1.
- CNT_W, 8, width of run_len and thresh.
- FILL_GATE, 1, 1 = no compare until history holds `lag` samples; 0 = compare against reset-zero history (legacy behaviour).

Ports:
- clk  in  1  rising-edge clock.
- n_reset  in  1  synchronous active-low reset.
- in_valid  in  1  din carries a new sample this cycle.
- din  in  WIDTH  sample data.
- lag  in  LAG_W = $clog2(MAX_LAG+1)  comparison distance in samples; legal range 1..MAX_LAG.
- thresh  in  CNT_W  consecutive matches required for lock; 0 disables lock.
- match  out  1  registered; 1 for one cycle after a matching valid sample.
- run_len  out  CNT_W  consecutive-match count, saturating.
- locked  out  1  run_len >= thresh and thresh != 0.
- hist_full  out  1  history holds MAX_LAG samples.
- lag_err  out  1  registered; lag illegal this cycle.

Behaviour:
- Reset (n_reset=0 at posedge):
  - All history entries are cleared to 0, and fill_cnt, lag_q, match, run_len, locked, hist_full and lag_err are cleared to 0.
  - Applies mid-stream; the history is lost.
- History:
  - hist[1..MAX_LAG] shifts only when in_valid=1: hist[1] <= din, hist[k] <= hist[k-1].
  - hist[k] always holds the k-th most recent valid sample.
  - fill_cnt increments on each valid sample and saturates at MAX_LAG. hist_full is registered as (fill_cnt == MAX_LAG).
- Compare (combinational, in the same cycle as the valid sample):
  - lag_ok = (lag >= 1) && (lag <= MAX_LAG).
  - avail = FILL_GATE ? (fill_cnt >= lag) : 1.
  - cmp = in_valid && lag_ok && avail && (din == hist[lag]), using the pre-shift history.
- Outputs, latency 1 cycle:
  - match <= cmp.
  - match=0 on any cycle with in_valid=0.
- run_len:
  - If lag != lag_q (lag changed since the previous cycle): run_len <= cmp ? 1 : 0.
  - Else if in_valid: run_len <= cmp ? sat_inc(run_len) : 0. sat_inc holds at 2^CNT_W-1.
  - Else: hold.
  - lag_q <= lag every cycle.
- locked:
  - locked <= (thresh != 0) && (run_len_next >= thresh), evaluated every cycle, so a thresh change takes effect on the next edge.
  - An illegal lag forces cmp=0, so the next valid sample clears run_len and locked.
- lag_err:
  - lag_err <= !lag_ok every cycle, regardless of in_valid.
  - The history keeps shifting while lag is illegal.
- Simultaneous lag change and valid mismatch: run_len=0, locked=0.
- Simultaneous reset and valid: reset wins; the sample is dropped.
- Legacy equivalence: with FILL_GATE=0, lag=2 and in_valid tied to 1, match is cycle-for-cycle identical to the existing 2-stage period checker.

Decomposition:
- Package cycle_det_pkg:
  - LAG_W computation function.
  - Saturating-increment function.
  - Default parameter constants.
- Sub-module cycle_hist:
  - Valid-gated WIDTH x MAX_LAG shift register, fill counter, and tap mux returning hist[lag].
  - The top level holds the compare, run/lock logic and output registers.

Test Plan:
- Reset then steady valid, lag=2, thresh=3, din=A,B,A,B,A,B (A=8'h5A, B=8'hC3) -> match=0,0,1,1,1,1 (each one cycle after its sample); run_len 1,2,3,4; locked rises with run_len=3; hist_full=0 until 8 samples.
- Same stream with in_valid deasserted every other cycle -> history and run_len hold on idle cycles, match=0 on idle cycles, same match sequence per valid sample.
- Locked at lag=2, switch to lag=3 on a non-matching sample -> next edge run_len=0, locked=0; pattern A,B,C repeated (C=8'h11) relocks after 3 matches.
- lag=0, then lag=9 with MAX_LAG=8 -> lag_err=1 the next cycle, match=0, run_len clears on the next valid; restoring lag=2 clears lag_err.
- FILL_GATE=0, lag=2, din=0,0,0 right after reset -> match=1 on the first two samples (compare vs reset zeros); with FILL_GATE=1 -> match=0,0,1.
- CNT_W=4, constant din for 20 samples at lag=1 -> run_len saturates at 15 and stays; n_reset pulsed mid-run -> all outputs 0 next edge, first post-reset sample gives match=0.
